// File: rtl/imm_pkg.sv
// Shared types for the immediate generator: selector encoding and format helpers.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_sel_e;

  localparam logic [2:0] IMM_SEL_LAST = 3'd4;

  // Only PC-relative control-flow formats can produce a misaligned target.
  function automatic logic is_bj(input logic [2:0] sel);
    return (sel == IMM_B) || (sel == IMM_J);
  endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational I/S/B/U/J immediate decode, sign-extended from bit 31 to XLEN.
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_sel,
  output logic [XLEN-1:0] imm,
  output logic            err
);

  logic [31:0] imm32;
  logic        unused_opcode;

  assign unused_opcode = ^instr[6:0];
  assign err           = imm_sel > IMM_SEL_LAST;

  always_comb begin
    imm32 = '0;
    case (imm_sel)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // U is sign-extended from bit 31 as well, so one extension covers all formats.
  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with pc+imm target, illegal-selector and misalign flags.
// One cycle latency; valid/ready on both sides with an optional skid entry.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int IALIGN = 32,
  parameter int SKID   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_sel,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm_out,
  output logic [XLEN-1:0] target_out,
  output logic            imm_err,
  output logic            tgt_misalign
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic            err;
    logic            misalign;
  } imm_res_t;

  imm_res_t        in_res;
  imm_res_t        out_res;
  logic [XLEN-1:0] ext_imm;
  logic            ext_err;
  logic [XLEN-1:0] sum;
  logic            in_fire;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr  (instr),
    .imm_sel(imm_sel),
    .imm    (ext_imm),
    .err    (ext_err)
  );

  // Illegal selectors decode to imm=0, so the sum naturally yields target=pc.
  assign sum     = pc + ext_imm;
  assign in_fire = in_valid && in_ready;

  always_comb begin
    in_res          = '0;
    in_res.imm      = ext_imm;
    in_res.target   = sum;
    in_res.err      = ext_err;
    in_res.misalign = 1'b0;
    if (is_bj(imm_sel)) begin
      in_res.misalign = (IALIGN == 16) ? sum[0] : |sum[1:0];
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      imm_res_t skid_res;
      logic     skid_valid;

      assign in_ready = !skid_valid;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid  <= 1'b0;
          out_res    <= '0;
          skid_valid <= 1'b0;
          skid_res   <= '0;
        end else if (!out_valid || out_ready) begin
          if (skid_valid) begin
            out_res    <= skid_res;
            out_valid  <= 1'b1;
            skid_valid <= 1'b0;
          end else if (in_fire) begin
            out_res   <= in_res;
            out_valid <= 1'b1;
          end else begin
            out_valid <= 1'b0;
          end
        end else if (in_fire) begin
          skid_res   <= in_res;
          skid_valid <= 1'b1;
        end
      end
    end else begin : g_noskid
      assign in_ready = !out_valid || out_ready;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid <= 1'b0;
          out_res   <= '0;
        end else if (in_fire) begin
          out_res   <= in_res;
          out_valid <= 1'b1;
        end else if (out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  endgenerate

  assign imm_out      = out_res.imm;
  assign target_out   = out_res.target;
  assign imm_err      = out_res.err;
  assign tgt_misalign = out_res.misalign;

  a_xlen_legal: assert property (@(posedge clk) (XLEN == 32) || (XLEN == 64));

  a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid && !out_ready |=> $stable(out_res));

  a_valid_held: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid && !out_ready |=> out_valid);

endmodule
